// File: rtl/memory_interface.sv
// Word-addressed memory behind MAR/MDR with a fixed access latency and Done/Busy handshake.
// Optional BOUNDS_CHECK_EN: flags out-of-range MAR addresses on Err and suppresses the access.
module memory_interface #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] MAR_addr,
    input  logic [31:0] MDR_data,
    output logic [31:0] Mdatain,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_W-1:0]       wdata;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic                    accept;
    logic                    fire;
    logic                    oob;

    // Next-state decode; accept/fire mark request acceptance and the access edge
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                if (Read || Write) begin
                    accept  = 1'b1;
                    state_n = Read ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt == '0) begin
                    fire    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Handshake flags follow the next state so they are glitch-free flops
    always_ff @(posedge clock) begin
        if (clear) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_n == RD_WAIT) || (state_n == WR_WAIT);
            Done <= (state_n == DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt     <= '0;
            Mdatain <= '0;
        end else begin
            if (accept) begin
                addr  <= MAR_addr[ADDR_WIDTH-1:0];
                wdata <= MDR_data;
                cnt   <= CNT_W'(LATENCY - 1);
            end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (fire && (state == RD_WAIT)) begin
                Mdatain <= oob ? '0 : mem[addr];
            end
        end
    end

    // Array is never reset; an aborted write never reaches it
    always_ff @(posedge clock) begin
        if (!clear && fire && (state == WR_WAIT) && !oob) begin
            mem[addr] <= wdata;
        end
    end

`ifdef BOUNDS_CHECK_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            oob <= 1'b0;
            Err <= 1'b0;
        end else if (accept) begin
            oob <= |MAR_addr[31:ADDR_WIDTH];
            Err <= 1'b0;
        end else if (fire && oob) begin
            Err <= 1'b1;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^MAR_addr[31:ADDR_WIDTH];
    assign oob       = 1'b0;
    assign Err       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: default LATENCY=2 instance plus a LATENCY=1 instance.
module tb_memory_interface;

    logic        clock;
    logic        clear;
    logic        Read, Write;
    logic [31:0] MAR_addr, MDR_data, Mdatain;
    logic        Busy, Done, Err;

    logic        Read1, Write1;
    logic [31:0] MAR1, MDR1, Mdatain1;
    logic        Busy1, Done1, Err1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rdata;
    logic        rerr;
    logic [31:0] words1 [3];

    memory_interface dut (
        .clock(clock), .clear(clear), .Read(Read), .Write(Write),
        .MAR_addr(MAR_addr), .MDR_data(MDR_data), .Mdatain(Mdatain),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    memory_interface #(.ADDR_WIDTH(9), .LATENCY(1)) dut1 (
        .clock(clock), .clear(clear), .Read(Read1), .Write(Write1),
        .MAR_addr(MAR1), .MDR_data(MDR1), .Mdatain(Mdatain1),
        .Busy(Busy1), .Done(Done1), .Err(Err1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One LATENCY=2 transaction; MAR/MDR are scrambled right after acceptance
    task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] data, output logic e);
        Read = rd; Write = wr; MAR_addr = a; MDR_data = d;
        step();
        Read = 1'b0; Write = 1'b0; MAR_addr = ~a; MDR_data = ~d;
        chk1("busy_k1", Busy, 1'b1);
        chk1("done_k1", Done, 1'b0);
        step();
        chk1("busy_k2", Busy, 1'b1);
        chk1("done_k2", Done, 1'b0);
        step();
        chk1("done_k3", Done, 1'b1);
        chk1("busy_k3", Busy, 1'b0);
        data = Mdatain;
        e    = Err;
        step();
        chk1("done_k4", Done, 1'b0);
        chk("mdatain_hold", Mdatain, data);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        Write1 = 1'b1; MAR1 = a; MDR1 = d;
        for (int n = 0; n < 10 && !got; n++) begin
            step();
            if (Done1) got = 1'b1;
        end
        Write1 = 1'b0;
        chk1("l1_write_done", got, 1'b1);
        step();
    endtask

    initial begin
        clear = 1'b1; Read = 1'b0; Write = 1'b0; MAR_addr = '0; MDR_data = '0;
        Read1 = 1'b0; Write1 = 1'b0; MAR1 = '0; MDR1 = '0;
        words1[0] = 32'h0000_00A1; words1[1] = 32'h0000_00B2; words1[2] = 32'h0000_00C3;

        step();
        step();
        clear = 1'b0;
        chk("rst_mdatain", Mdatain, 32'h0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        chk1("rst_err", Err, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("idle_busy", Busy, 1'b0);
            chk1("idle_done", Done, 1'b0);
            chk("idle_mdatain", Mdatain, 32'h0);
        end

        xact(1'b0, 1'b1, 32'h05, 32'hDEAD_BEEF, rdata, rerr);
        xact(1'b1, 1'b0, 32'h05, 32'h0, rdata, rerr);
        chk("rd_05", rdata, 32'hDEAD_BEEF);
        step();
        chk("rd_05_held", Mdatain, 32'hDEAD_BEEF);

        xact(1'b0, 1'b1, 32'h10, 32'h1234, rdata, rerr);
        xact(1'b1, 1'b1, 32'h10, 32'hFFFF, rdata, rerr);
        chk("rw_both_read", rdata, 32'h1234);
        xact(1'b1, 1'b0, 32'h10, 32'h0, rdata, rerr);
        chk("rw_both_nowrite", rdata, 32'h1234);

        // Abort a write with clear in the middle of its wait
        xact(1'b0, 1'b1, 32'h20, 32'h1111, rdata, rerr);
        Write = 1'b1; MAR_addr = 32'h20; MDR_data = 32'hAAAA_5555;
        step();
        Write = 1'b0;
        chk1("abort_busy", Busy, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk1("abort_busy_clr", Busy, 1'b0);
        chk("abort_mdatain", Mdatain, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("abort_no_done", Done, 1'b0);
        end
        xact(1'b1, 1'b0, 32'h20, 32'h0, rdata, rerr);
        chk("abort_old_value", rdata, 32'h1111);
        xact(1'b1, 1'b0, 32'h05, 32'h0, rdata, rerr);
        chk("mem_survives_clear", rdata, 32'hDEAD_BEEF);

        xact(1'b0, 1'b1, 32'h205, 32'h77, rdata, rerr);
`ifdef BOUNDS_CHECK_EN
        chk1("oob_wr_err", rerr, 1'b1);
        chk1("oob_err_held", Err, 1'b1);
        xact(1'b1, 1'b0, 32'h005, 32'h0, rdata, rerr);
        chk("oob_no_write", rdata, 32'hDEAD_BEEF);
        chk1("inb_err", rerr, 1'b0);
        xact(1'b1, 1'b0, 32'h205, 32'h0, rdata, rerr);
        chk("oob_rd_zero", rdata, 32'h0);
        chk1("oob_rd_err", rerr, 1'b1);
`else
        chk1("wrap_err", rerr, 1'b0);
        xact(1'b1, 1'b0, 32'h005, 32'h0, rdata, rerr);
        chk("wrap_read", rdata, 32'h77);
        chk1("wrap_rd_err", rerr, 1'b0);
`endif

        // LATENCY=1: back-to-back reads with Read held give Done every third cycle
        wr1(32'h1, words1[0]);
        wr1(32'h2, words1[1]);
        wr1(32'h3, words1[2]);
        MAR1 = 32'h1;
        Read1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk1("l1_done", Done1, (i % 3) == 2);
            chk1("l1_busy", Busy1, (i % 3) == 1);
            if ((i % 3) == 2) begin
                chk("l1_data", Mdatain1, words1[i / 3]);
                if (i / 3 < 2) MAR1 = 32'((i / 3) + 2);
                else Read1 = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
